// File: rtl/hci_package.sv
// Shared types and constants for the HCI QoS bank arbiter and its routing FIFO.
package hci_package;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int STALL_W = 16;

endpackage

// File: rtl/hci_qos_id_fifo.sv
// In-order FIFO of granted initiator ids, used to route bank responses back.
module hci_qos_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] incr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];

  // Storage is only read while non-empty, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= incr(wr_q);
      if (do_pop)  rd_q <= incr(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/hci_qos_bank_arbiter.sv
// Arbitrates N_IN initiators onto one memory bank with a starvation override and in-order response routing.
// Define HCI_QOS_STATS_EN to build the per-input maximum stall statistics.
module hci_qos_bank_arbiter
  import hci_package::*;
#(
  parameter int N_IN        = 3,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int BW          = 8,
  parameter int ARB_MODE    = 1,
  parameter int MAX_STALL   = 16,
  parameter int OUTSTANDING = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic [N_IN-1:0]           in_req_i,
  output logic [N_IN-1:0]           in_gnt_o,
  input  logic [N_IN*AW-1:0]        in_add_i,
  input  logic [N_IN-1:0]           in_wen_i,
  input  logic [N_IN*DW-1:0]        in_data_i,
  input  logic [N_IN*(DW/BW)-1:0]   in_be_i,
  output logic [DW-1:0]             in_r_data_o,
  output logic [N_IN-1:0]           in_r_valid_o,
  output logic                      mem_req_o,
  output logic [AW-1:0]             mem_add_o,
  output logic                      mem_wen_o,
  output logic [DW-1:0]             mem_data_o,
  output logic [DW/BW-1:0]          mem_be_o,
  input  logic                      mem_gnt_i,
  input  logic [DW-1:0]             mem_r_data_i,
  input  logic                      mem_r_valid_i,
  output logic [N_IN*STALL_W-1:0]   stall_max_o,
  output logic                      err_o
);

  localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int BEW = DW / BW;
  localparam int SCW = $clog2(MAX_STALL + 1);

  logic [IW-1:0]  rr_q;
  logic [IW-1:0]  win;
  logic [IW-1:0]  head;
  logic [SCW-1:0] stall_q [N_IN];
  logic [N_IN-1:0] starved;
  logic           fifo_full;
  logic           fifo_empty;
  logic           hs;
  logic           pop;

  always_comb begin
    for (int i = 0; i < N_IN; i++) starved[i] = (stall_q[i] == SCW'(MAX_STALL));
  end

  // A starved requester always wins; otherwise scan from index 0 or from the round-robin pointer.
  always_comb begin
    logic        found;
    logic [IW:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (!found && in_req_i[i] && starved[i]) begin
        win   = IW'(i);
        found = 1'b1;
      end
    end
    for (int k = 0; k < N_IN; k++) begin
      if (ARB_MODE == int'(ARB_RR)) begin
        idx = {1'b0, rr_q} + (IW+1)'(k);
        if (idx >= (IW+1)'(N_IN)) idx = idx - (IW+1)'(N_IN);
      end else begin
        idx = (IW+1)'(k);
      end
      if (!found && in_req_i[idx]) begin
        win   = idx[IW-1:0];
        found = 1'b1;
      end
    end
  end

  assign mem_req_o   = (|in_req_i) & ~fifo_full;
  assign hs          = mem_req_o & mem_gnt_i;
  assign pop         = mem_r_valid_i & ~fifo_empty;
  assign mem_add_o   = in_add_i[win*AW +: AW];
  assign mem_wen_o   = in_wen_i[win];
  assign mem_data_o  = in_data_i[win*DW +: DW];
  assign mem_be_o    = in_be_i[win*BEW +: BEW];
  assign in_r_data_o = mem_r_data_i;

  always_comb begin
    in_gnt_o      = '0;
    in_gnt_o[win] = hs;
    in_r_valid_o  = '0;
    if (pop) in_r_valid_o[head] = 1'b1;
  end

  hci_qos_id_fifo #(
    .W     (IW),
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (hs),
    .data_i  (win),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A response with nothing outstanding is dropped and flagged until reset or clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q  <= '0;
      err_o <= 1'b0;
    end else if (clear_i) begin
      rr_q  <= '0;
      err_o <= 1'b0;
    end else begin
      if (hs) rr_q <= (win == IW'(N_IN - 1)) ? '0 : win + IW'(1);
      if (mem_r_valid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_IN; i++) stall_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < N_IN; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (in_req_i[i] && !in_gnt_o[i]) begin
          if (!starved[i]) stall_q[i] <= stall_q[i] + SCW'(1);
        end else begin
          stall_q[i] <= '0;
        end
      end
    end
  end

`ifdef HCI_QOS_STATS_EN
  for (genvar g = 0; g < N_IN; g++) begin : g_stats
    logic [STALL_W-1:0] run_q;
    logic [STALL_W-1:0] run_d;
    logic [STALL_W-1:0] max_q;

    // The statistics run ignores MAX_STALL and saturates only at its own width.
    assign run_d = (in_req_i[g] && !in_gnt_o[g]) ?
                   ((run_q == {STALL_W{1'b1}}) ? run_q : run_q + STALL_W'(1)) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        run_q <= '0;
        max_q <= '0;
      end else if (clear_i) begin
        run_q <= '0;
        max_q <= '0;
      end else begin
        run_q <= run_d;
        if (run_d > max_q) max_q <= run_d;
      end
    end

    assign stall_max_o[g*STALL_W +: STALL_W] = max_q;
  end
`else
  assign stall_max_o = '0;
`endif

endmodule
